ads7843_spi_master: RTL and testbench

//  Hardware SPI master for the ADS7843 touch-screen controller on the 2.4" TFT board. Replaces
//  CPU bit-banging of the ads_clk/ads_cs/ads_din PIOs: the Nios II writes one 8-bit control byte
//  and the block runs a complete 24-DCLK conversion frame, returning the 12-bit result.

---
 rtl/ads7843_spi_master.sv | 152 +++++++++++++++
 tb/tb_ads7843_spi_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ads7843_spi_master.sv
// Avalon-MM SPI master for the ADS7843 touch controller: one CMD write runs a full
// 24-DCLK conversion frame and leaves the 12-bit result in RESULT.
module ads7843_spi_master #(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ads_dout,
  input  logic        ads_penirq_n,
  output logic        ads_clk,
  output logic        ads_cs_n,
  output logic        ads_din
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  localparam logic [7:0] CNT_LAST  = 8'(DIV_HALF - 1);
  localparam logic [5:0] LAST_HALF = 6'd48;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [5:0]  half_q;
  logic [7:0]  cmd_q;
  logic [11:0] shift_q;
  logic [11:0] result_q;
  logic        busy_q;
  logic        done_q;
  logic        dclk_q;
  logic        cs_n_q;
  logic        din_q;
  logic [1:0]  dout_sync_q;
  logic [1:0]  pen_sync_q;

  logic        accept;
  logic        result_rd;
  logic        cnt_wrap;
  logic        sample_en;
  logic        pen_down;
  logic [5:0]  half_d;
  logic [7:0]  cnt_d;
  logic [2:0]  din_idx;
  logic        unused_wdata;

  assign accept    = chipselect & ~write_n & (address == 2'd0) & ~busy_q;
  assign result_rd = chipselect & ~read_n & (address == 2'd2);
  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign cnt_d     = cnt_q + 8'd1;
  assign half_d    = half_q + 6'd1;
  // DOUT is captured at the end of the high phase of DCLK periods 10..21.
  assign sample_en = half_q[0] && (half_q >= 6'd19) && (half_q <= 6'd41);
  assign din_idx   = 3'd7 - half_d[3:1];
  assign pen_down  = ~pen_sync_q[1];

  assign unused_wdata = ^writedata[31:8];

  assign ads_clk  = dclk_q;
  assign ads_cs_n = cs_n_q;
  assign ads_din  = din_q;

  // NOTE: every register here is assigned with <= so all of them update from the same
  // pre-edge values; a blocking = would let later statements see the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      cmd_q       <= '0;
      shift_q     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      din_q       <= 1'b0;
      dout_sync_q <= '0;
      pen_sync_q  <= 2'b11;
    end else begin
      dout_sync_q <= {dout_sync_q[0], ads_dout};
      pen_sync_q  <= {pen_sync_q[0], ads_penirq_n};

      // A frame-end set further down overrides this clear.
      if (accept || result_rd) done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            cmd_q   <= writedata[7:0];
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            din_q   <= writedata[7];
            half_q  <= '0;
            shift_q <= '0;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cnt_wrap) begin
            cnt_q  <= '0;
            half_q <= half_d;
            dclk_q <= half_d[0];
            if (sample_en) shift_q <= {shift_q[10:0], dout_sync_q[1]};
            // Falls 1..7 present the next command bit; from fall 8 DIN idles low.
            if (!half_d[0]) din_q <= (half_d <= 6'd14) ? cmd_q[din_idx] : 1'b0;
            if (half_d == LAST_HALF) state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_HOLD: begin
          if (cnt_wrap) begin
            cnt_q    <= '0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= shift_q;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: readdata gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {24'b0, cmd_q};
      2'd1:    readdata = {29'b0, pen_down, done_q, busy_q};
      2'd2:    readdata = {20'b0, result_q};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ads7843_spi_master.sv
// Directed bench for ads7843_spi_master: DUT A at DIV_HALF=4 and DUT B at DIV_HALF=3
// share the bus; each has its own behavioural ADS7843 returning 0xA5C.
module tb_ads7843_spi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic        penirq_n;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  aclk, acs_n, adin, adout;
  logic [11:0] ads_val = 12'hA5C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ads7843_spi_master #(.DIV_HALF(4)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_a),
    .ads_dout(adout[0]), .ads_penirq_n(penirq_n),
    .ads_clk(aclk[0]), .ads_cs_n(acs_n[0]), .ads_din(adin[0])
  );

  ads7843_spi_master #(.DIV_HALF(3)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd_b),
    .ads_dout(adout[1]), .ads_penirq_n(penirq_n),
    .ads_clk(aclk[1]), .ads_cs_n(acs_n[1]), .ads_din(adin[1])
  );

  // ADS7843 model: captures DIN on rises 1..8, drives D11..D0 after falls 9..20.
  for (genvar g = 0; g < 2; g++) begin : g_ads
    int         rises = 0;
    int         falls = 0;
    logic [7:0] din_cap = '0;
    logic       din_late = 1'b0;
    logic       dout = 1'b0;
    assign adout[g] = dout;

    always @(negedge acs_n[g]) begin
      rises    <= 0;
      falls    <= 0;
      din_cap  <= '0;
      din_late <= 1'b0;
      dout     <= 1'b0;
    end

    always @(posedge aclk[g]) begin
      if (acs_n[g] === 1'b0) begin
        rises <= rises + 1;
        if (rises < 8) din_cap <= {din_cap[6:0], adin[g]};
        else if (adin[g] !== 1'b0) din_late <= 1'b1;
      end
    end

    always @(negedge aclk[g]) begin
      if (acs_n[g] === 1'b0) begin
        falls <= falls + 1;
        dout  <= (falls >= 8 && falls <= 19) ? ads_val[19 - falls] : 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  // One-cycle write; returns #1 into the cycle after the accept cycle (T1).
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_strobe(input logic [1:0] a);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    tick();
    bus_idle();
  endtask

  // Side-effect-free look at the read mux of both DUTs.
  task automatic peek(input logic [1:0] a, output logic [31:0] va, output logic [31:0] vb);
    address = a;
    #1;
    va = rd_a;
    vb = rd_b;
    address = 2'd0;
  endtask

  initial begin
    logic [31:0] va, vb;
    int na, nb, n;
    bit reached;

    bus_idle();
    penirq_n = 1'b1;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset held for 3 cycles while idle.
    reset = 1'b1;
    repeat (3) tick();
    check("rst_cs_n", 32'(acs_n[0]), 32'd1);
    check("rst_dclk", 32'(aclk[0]), 32'd0);
    check("rst_din", 32'(adin[0]), 32'd0);
    peek(2'd1, va, vb);
    check("rst_status", va, 32'h0);
    peek(2'd0, va, vb);
    check("rst_cmd", va, 32'h0);
    reset = 1'b0;
    tick();

    // Reset mid-frame at DCLK rise 12 of DUT A.
    wr(2'd0, 32'h93);
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (g_ads[0].rises == 12 && aclk[0] === 1'b1) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("midrst_reached_rise12", 32'(reached), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_cs_n", 32'(acs_n[0]), 32'd1);
    check("midrst_dclk", 32'(aclk[0]), 32'd0);
    check("midrst_b_cs_n", 32'(acs_n[1]), 32'd1);
    peek(2'd1, va, vb);
    check("midrst_status", va, 32'h0);
    peek(2'd2, va, vb);
    check("midrst_result", va, 32'h0);
    reset = 1'b0;
    repeat (4) tick();
    check("midrst_idle_dclk", 32'(aclk[0]), 32'd0);

    // Full frame with 0x93 on both DUTs; busy counted through STATUS.
    wr(2'd0, 32'h93);
    na = 0;
    nb = 0;
    address = 2'd1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (rd_a[0]) na++;
      if (rd_b[0]) nb++;
      if (!rd_a[0] && !rd_b[0]) break;
      tick();
    end
    bus_idle();
    check("frame_busy_a_h4", 32'(na), 32'd196);
    check("frame_busy_b_h3", 32'(nb), 32'd147);
    check("frame_rises_a", 32'(g_ads[0].rises), 32'd24);
    check("frame_rises_b", 32'(g_ads[1].rises), 32'd24);
    check("frame_din_a", 32'(g_ads[0].din_cap), 32'h93);
    check("frame_din_b", 32'(g_ads[1].din_cap), 32'h93);
    check("frame_din_low_after8", 32'(g_ads[0].din_late), 32'd0);
    peek(2'd2, va, vb);
    check("frame_result_a", va, 32'h00000A5C);
    check("frame_result_b", vb, 32'h00000A5C);
    peek(2'd1, va, vb);
    check("frame_status_a", va, 32'h2);
    check("frame_status_b", vb, 32'h2);

    // RESULT read clears done; the value stays readable.
    rd_strobe(2'd2);
    peek(2'd1, va, vb);
    check("clr_status_a", va, 32'h0);
    check("clr_status_b", vb, 32'h0);
    peek(2'd2, va, vb);
    check("clr_result_again", va, 32'h00000A5C);

    // A write to STATUS must not start a frame.
    wr(2'd1, 32'h93);
    repeat (3) tick();
    check("wr_addr1_cs_n", 32'(acs_n[0]), 32'd1);
    peek(2'd1, va, vb);
    check("wr_addr1_status", va, 32'h0);

    // CMD write of 0xD3 during cycle T1+40 of a 0x93 frame is ignored.
    wr(2'd0, 32'h93);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 40) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'hD3;
      end
      if (i == 41) bus_idle();
      if (acs_n[0] === 1'b0) n++;
      else if (i > 41) break;
      tick();
    end
    bus_idle();
    check("busywr_cs_low_cycles", 32'(n), 32'd196);
    check("busywr_din", 32'(g_ads[0].din_cap), 32'h93);
    check("busywr_rises", 32'(g_ads[0].rises), 32'd24);
    peek(2'd0, va, vb);
    check("busywr_cmd_a", va, 32'h93);
    check("busywr_cmd_b", vb, 32'h93);
    repeat (30) tick();
    check("busywr_no_2nd_frame", 32'(acs_n[0]), 32'd1);
    check("busywr_rises_after", 32'(g_ads[0].rises), 32'd24);
    peek(2'd2, va, vb);
    check("busywr_result", va, 32'h00000A5C);

    // Pen down appears in STATUS within 3 cycles.
    penirq_n = 1'b0;
    va = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      peek(2'd1, va, vb);
      if (va[2]) break;
    end
    check("pen_status_a", va, 32'h6);
    check("pen_status_b", vb, 32'h6);
    penirq_n = 1'b1;
    repeat (3) tick();
    peek(2'd1, va, vb);
    check("pen_release", va, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
